// File: rtl/mem_master_pkg.sv
// ============================================================================
// mem_master_pkg : shared types and mode encodings for the burst master.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_master_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_WAIT  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [1:0] MODE_WR    = 2'b00;
    localparam logic [1:0] MODE_RDCHK = 2'b01;
    localparam logic [1:0] MODE_WRRD  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_pattern_gen.sv
// ============================================================================
// mem_pattern_gen : maps (start address, seed, beat) to beat address and data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_pattern_gen #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [WIDTH-1:0]      seed,
    input  logic [ADDR_WIDTH:0]   beat,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      data
);

    // Address arithmetic wraps naturally at the top of the memory.
    assign addr = base + beat[ADDR_WIDTH-1:0];
    assign data = seed + WIDTH'(beat);

endmodule

`default_nettype wire

// File: rtl/mem_burst_master.sv
// ============================================================================
// mem_burst_master : write / read-check burst sequencer for a single-port memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_burst_master
    import mem_master_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [WIDTH-1:0]      cmd_seed,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic                  ready,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  timeout
);

    localparam int LEN_W  = ADDR_WIDTH + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_mode;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_W-1:0]      r_len;
    logic [WIDTH-1:0]      r_seed;
    logic [LEN_W-1:0]      r_beat;
    logic [LEN_W-1:0]      w_beat_next;
    logic [WAIT_W-1:0]     r_wait;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_expired;
    logic                  w_rd_beat;
    logic                  w_mismatch;

    logic [ADDR_WIDTH-1:0] w_iss_base;
    logic [WIDTH-1:0]      w_iss_seed;
    logic [ADDR_WIDTH-1:0] w_iss_addr;
    logic [WIDTH-1:0]      w_iss_data;
    logic [ADDR_WIDTH-1:0] w_chk_addr;
    logic [WIDTH-1:0]      w_chk_data;

    // The issue-side generator looks at the next beat, and on accept the
    // command fields have not been latched yet, so take them straight from the port.
    assign w_iss_base = (r_state == IDLE) ? cmd_addr : r_base;
    assign w_iss_seed = (r_state == IDLE) ? cmd_seed : r_seed;

    mem_pattern_gen #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pat_issue (
        .base (w_iss_base),
        .seed (w_iss_seed),
        .beat (w_beat_next),
        .addr (w_iss_addr),
        .data (w_iss_data)
    );

    mem_pattern_gen #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pat_check (
        .base (r_base),
        .seed (r_seed),
        .beat (r_beat),
        .addr (w_chk_addr),
        .data (w_chk_data)
    );

    assign w_last     = (r_beat == (r_len - LEN_W'(1)));
    assign w_expired  = ((r_state == WR_WAIT) || (r_state == RD_WAIT)) && !ready
                        && (r_wait == WAIT_W'(TIMEOUT - 1));
    assign w_mismatch = w_rd_beat && (rdata != w_chk_data);

    assign cmd_ready = (r_state == IDLE);
    assign valid     = (r_state == WR_ISSUE) || (r_state == RD_ISSUE);
    assign busy      = (r_state != IDLE) && (r_state != DONE);
    assign done      = (r_state == DONE);

    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_accept     = 1'b0;
        w_rd_beat    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_accept    = 1'b1;
                    w_beat_next = '0;
                    if (cmd_len == '0) begin
                        w_state_next = DONE;
                    end else if (cmd_mode == MODE_RDCHK) begin
                        w_state_next = RD_ISSUE;
                    end else begin
                        w_state_next = WR_ISSUE;
                    end
                end
            end
            WR_ISSUE: w_state_next = WR_WAIT;
            WR_WAIT: begin
                if (ready) begin
                    if (!w_last) begin
                        w_beat_next  = r_beat + LEN_W'(1);
                        w_state_next = WR_ISSUE;
                    end else if (r_mode == MODE_WRRD) begin
                        w_beat_next  = '0;
                        w_state_next = RD_ISSUE;
                    end else begin
                        w_state_next = DONE;
                    end
                end else if (w_expired) begin
                    w_state_next = DONE;
                end
            end
            RD_ISSUE: w_state_next = RD_WAIT;
            RD_WAIT: begin
                if (ready) begin
                    w_rd_beat = 1'b1;
                    if (w_last) begin
                        w_state_next = DONE;
                    end else begin
                        w_beat_next  = r_beat + LEN_W'(1);
                        w_state_next = RD_ISSUE;
                    end
                end else if (w_expired) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_mode         <= '0;
            r_base         <= '0;
            r_len          <= '0;
            r_seed         <= '0;
            r_beat         <= '0;
            r_wait         <= '0;
            addr           <= '0;
            wdata          <= '0;
            wr_rd          <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= w_beat_next;

            if (w_accept) begin
                r_mode         <= cmd_mode;
                r_base         <= cmd_addr;
                r_len          <= cmd_len;
                r_seed         <= cmd_seed;
                err_count      <= '0;
                first_err_addr <= '0;
                timeout        <= 1'b0;
            end

            // Request fields are registered on entry to an issue state and
            // then held, so they keep their last values once back in IDLE.
            if (w_state_next == WR_ISSUE) begin
                addr  <= w_iss_addr;
                wdata <= w_iss_data;
                wr_rd <= 1'b1;
            end else if (w_state_next == RD_ISSUE) begin
                addr  <= w_iss_addr;
                wr_rd <= 1'b0;
            end

            if ((w_state_next == WR_ISSUE) || (w_state_next == RD_ISSUE)) begin
                r_wait <= '0;
            end else if ((r_state == WR_WAIT) || (r_state == RD_WAIT)) begin
                r_wait <= r_wait + WAIT_W'(1);
            end

            if (w_expired) begin
                timeout <= 1'b1;
            end

            if (w_mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + LEN_W'(1);
                end
                if (err_count == '0) begin
                    first_err_addr <= w_chk_addr;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_master.sv
// ============================================================================
// tb_mem_burst_master : directed vector bench with a small memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_burst_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [3:0]  cmd_addr;
    logic [4:0]  cmd_len;
    logic [15:0] cmd_seed;
    logic        valid;
    logic        wr_rd;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic        ready;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic [4:0]  err_count;
    logic [3:0]  first_err_addr;
    logic        timeout;

    logic [15:0] mem [16];
    logic        hold_ready;

    int checks = 0;
    int errors = 0;

    mem_burst_master #(
        .WIDTH      (16),
        .ADDR_WIDTH (4),
        .TIMEOUT    (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_mode       (cmd_mode),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_seed       (cmd_seed),
        .valid          (valid),
        .wr_rd          (wr_rd),
        .addr           (addr),
        .wdata          (wdata),
        .ready          (ready),
        .rdata          (rdata),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers one cycle after it samples a request; hold_ready mutes it.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready <= 1'b0;
            rdata <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            ready <= valid && !hold_ready;
            if (valid && !hold_ready) begin
                if (wr_rd) mem[addr] <= wdata;
                else       rdata     <= mem[addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // lat = rising edges after the accept edge until done is visible.
    task automatic run_cmd(input logic [1:0] m, input logic [3:0] a, input logic [4:0] l,
                           input logic [15:0] s, output int lat, output int nv);
        bit got;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_seed  = s;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, (l != 0));
        lat = 0;
        nv  = 0;
        got = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            if (valid) nv++;
            if (done) got = 1;
            else      lat++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_wait: no done pulse within 200 cycles");
        end else begin
            check("busy_at_done", busy, 0);
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  a;
        logic [4:0]  len;
        logic [15:0] seed;
        int          exp_err;
        int          exp_first;
        int          exp_to;
        int          exp_lat;
        int          exp_nv;
        logic [3:0]  chk_a;
        logic [15:0] chk_d;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat;
        int nv;
        int seen;

        vecs[0] = '{2'd2, 4'd0,  5'd4,  16'h1000, 0, 0, 0, 16,  8, 4'd3, 16'h1003};
        vecs[1] = '{2'd2, 4'd14, 5'd4,  16'h2000, 0, 0, 0, 16,  8, 4'd0, 16'h2002};
        vecs[2] = '{2'd0, 4'd6,  5'd1,  16'h0006, 0, 0, 0,  2,  1, 4'd6, 16'h0006};
        vecs[3] = '{2'd0, 4'd5,  5'd1,  16'hDEAD, 0, 0, 0,  2,  1, 4'd5, 16'hDEAD};
        vecs[4] = '{2'd1, 4'd4,  5'd3,  16'h0004, 2, 4, 0,  6,  3, 4'd4, 16'h0000};
        vecs[5] = '{2'd3, 4'd8,  5'd2,  16'h00FF, 0, 0, 0,  4,  2, 4'd9, 16'h0100};
        vecs[6] = '{2'd1, 4'd8,  5'd2,  16'h00FF, 0, 0, 0,  4,  2, 4'd8, 16'h00FF};
        vecs[7] = '{2'd1, 4'd8,  5'd2,  16'h0100, 2, 8, 0,  4,  2, 4'd8, 16'h00FF};
        vecs[8] = '{2'd2, 4'd0,  5'd0,  16'h1234, 0, 0, 0,  0,  0, 4'd0, 16'h2002};
        vecs[9] = '{2'd2, 4'd3,  5'd16, 16'h4000, 0, 0, 0, 64, 32, 4'd2, 16'h400F};

        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_mode   = '0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_seed   = '0;
        hold_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_err_count", err_count, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].mode, vecs[i].a, vecs[i].len, vecs[i].seed, lat, nv);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_issues", i), nv, vecs[i].exp_nv);
            check($sformatf("v%0d_err_count", i), err_count, vecs[i].exp_err);
            check($sformatf("v%0d_first_err_addr", i), first_err_addr, vecs[i].exp_first);
            check($sformatf("v%0d_timeout", i), timeout, vecs[i].exp_to);
            check($sformatf("v%0d_mem", i), mem[vecs[i].chk_a], vecs[i].chk_d);
            if (i == 0) begin
                @(negedge clk);
                check("idle_valid_low", valid, 0);
                check("idle_addr_hold", addr, 3);
                check("idle_wdata_hold", wdata, 16'h1003);
                check("idle_wr_rd_hold", wr_rd, 0);
            end
        end

        // Memory never answers: burst aborts after TIMEOUT waiting cycles.
        hold_ready = 1'b1;
        run_cmd(2'd0, 4'd2, 5'd3, 16'h0055, lat, nv);
        check("to_latency", lat, 9);
        check("to_issues", nv, 1);
        check("to_flag", timeout, 1);
        check("to_mem_untouched", mem[2], 16'h400F);
        hold_ready = 1'b0;
        run_cmd(2'd0, 4'd2, 5'd1, 16'h0077, lat, nv);
        check("after_to_latency", lat, 2);
        check("after_to_flag", timeout, 0);
        check("after_to_mem", mem[2], 16'h0077);

        // Reset during the third beat of an 8-beat burst.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = 2'd2;
        cmd_addr  = 4'd0;
        cmd_len   = 5'd8;
        cmd_seed  = 16'h0010;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        nv = 0;
        lat = 0;
        while (nv < 3 && lat < 50) begin
            @(negedge clk);
            if (valid) nv++;
            lat++;
        end
        check("mid_burst_reached", nv, 3);
        check("mid_burst_valid", valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", valid, 0);
        check("arst_wr_rd", wr_rd, 0);
        check("arst_addr", addr, 0);
        check("arst_wdata", wdata, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err_count", err_count, 0);
        check("arst_first_err", first_err_addr, 0);
        check("arst_timeout", timeout, 0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("arst_no_done", seen, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        run_cmd(2'd0, 4'd7, 5'd1, 16'h0099, lat, nv);
        check("post_rst_latency", lat, 2);
        check("post_rst_mem", mem[7], 16'h0099);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
